// File: rtl/ex_stage_pkg.sv
// Shared constants for the Mipu EX stage: opcodes, CPU run state,
// pipeline NOP and the multiplier FSM encoding.
package ex_stage_pkg;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_HALT  = 5'd1;
    localparam logic [4:0] OP_LOAD  = 5'd2;
    localparam logic [4:0] OP_STORE = 5'd3;
    localparam logic [4:0] OP_LDIH  = 5'd4;
    localparam logic [4:0] OP_ADD   = 5'd5;
    localparam logic [4:0] OP_ADDI  = 5'd6;
    localparam logic [4:0] OP_ADDC  = 5'd7;
    localparam logic [4:0] OP_SUB   = 5'd8;
    localparam logic [4:0] OP_SUBI  = 5'd9;
    localparam logic [4:0] OP_SUBC  = 5'd10;
    localparam logic [4:0] OP_CMP   = 5'd11;
    localparam logic [4:0] OP_AND   = 5'd12;
    localparam logic [4:0] OP_OR    = 5'd13;
    localparam logic [4:0] OP_XOR   = 5'd14;
    localparam logic [4:0] OP_SLL   = 5'd15;
    localparam logic [4:0] OP_SRL   = 5'd16;
    localparam logic [4:0] OP_SLA   = 5'd17;
    localparam logic [4:0] OP_SRA   = 5'd18;
    localparam logic [4:0] OP_JUMP  = 5'd19;
    localparam logic [4:0] OP_JMPR  = 5'd20;
    localparam logic [4:0] OP_BZ    = 5'd21;
    localparam logic [4:0] OP_BNZ   = 5'd22;
    localparam logic [4:0] OP_BN    = 5'd23;
    localparam logic [4:0] OP_BNN   = 5'd24;
    localparam logic [4:0] OP_BC    = 5'd25;
    localparam logic [4:0] OP_BNC   = 5'd26;
    localparam logic [4:0] OP_MUL   = 5'd27;

    localparam logic CPU_IDLE = 1'b0;
    localparam logic CPU_EXEC = 1'b1;

    localparam logic [15:0] NOP = 16'h0000;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_MULT = 1'b1
    } mul_state_t;

endpackage

// File: rtl/ex_stage_mul16_iter.sv
// Iterative 16x16 shift-add multiplier, one partial product per cycle,
// low 16 bits of the product kept. Only instantiated when MUL_EN is defined.
module mul16_iter
    import ex_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic        active,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    mul_state_t  state_q;
    mul_state_t  state_d;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [15:0] acc;
    logic [15:0] addend;
    logic [3:0]  count;
    logic        last;

    assign last = (count == 4'd15);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= MUL_IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MUL_IDLE: if (start) state_d = MUL_MULT;
            MUL_MULT: if (last) state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_comb begin
        active = (state_q == MUL_MULT);
        busy   = active && !last;
        done   = active && last;
    end

    // product already includes this cycle's partial term, so it is final when done
    assign addend  = mplier[count] ? (mcand << count) : 16'h0000;
    assign product = acc + addend;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (enable) begin
            if (state_q == MUL_IDLE && start) begin
                mcand  <= multiplicand;
                mplier <= multiplier;
                acc    <= '0;
                count  <= '0;
            end else if (state_q == MUL_MULT) begin
                acc    <= product;
                count  <= count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Mipu EX stage: ALU, flags, branch resolve and EX/MEM register.
// Define MUL_EN to add the 16-cycle iterative multiplier and ex_busy stall.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic [15:0] ex_ir,
    input  logic [15:0] reg_A,
    input  logic [15:0] reg_B,
    input  logic [15:0] smdr,
    output logic [15:0] mem_ir,
    output logic [15:0] reg_C,
    output logic [15:0] smdr1,
    output logic        dw,
    output logic        zf,
    output logic        nf,
    output logic        cf,
    output logic        branch_flag,
    output logic [15:0] branch_addr,
    output logic        ex_busy
);

    logic [4:0]  op;
    logic        run;
    logic [16:0] sum;
    logic [15:0] alu_c;
    logic        cf_nx;
    logic        zn_upd;
    logic        dw_nx;
    logic        taken;
    logic        mul_start;
    logic        mul_active;
    logic        mul_busy;
    logic        mul_done;
    logic [15:0] mul_product;

    assign op          = ex_ir[15:11];
    assign run         = (state == CPU_EXEC);
    assign branch_addr = reg_A + reg_B;

`ifdef MUL_EN
    logic mul_req;

    assign mul_req   = (op == OP_MUL);
    assign mul_start = run && mul_req && !mul_active;
    assign ex_busy   = (!mul_active && mul_req) || mul_busy;

    mul16_iter u_mul (
        .clock        (clock),
        .reset        (reset),
        .enable       (run),
        .start        (mul_start),
        .multiplicand (reg_A),
        .multiplier   (reg_B),
        .active       (mul_active),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );
`else
    assign mul_start   = 1'b0;
    assign mul_active  = 1'b0;
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = 16'h0000;
    assign ex_busy     = 1'b0;
`endif

    always_comb begin
        sum    = '0;
        alu_c  = '0;
        cf_nx  = cf;
        zn_upd = 1'b0;
        dw_nx  = 1'b0;
        unique case (op)
            OP_ADD, OP_ADDI, OP_LDIH: begin
                sum    = {1'b0, reg_A} + {1'b0, reg_B};
                alu_c  = sum[15:0];
                cf_nx  = sum[16];
                zn_upd = 1'b1;
            end
            OP_ADDC: begin
                sum    = {1'b0, reg_A} + {1'b0, reg_B} + {16'h0000, cf};
                alu_c  = sum[15:0];
                cf_nx  = sum[16];
                zn_upd = 1'b1;
            end
            // bit 16 of the 17-bit difference is the borrow
            OP_SUB, OP_SUBI, OP_CMP: begin
                sum    = {1'b0, reg_A} - {1'b0, reg_B};
                alu_c  = sum[15:0];
                cf_nx  = sum[16];
                zn_upd = 1'b1;
            end
            OP_SUBC: begin
                sum    = {1'b0, reg_A} - {1'b0, reg_B} - {16'h0000, cf};
                alu_c  = sum[15:0];
                cf_nx  = sum[16];
                zn_upd = 1'b1;
            end
            OP_AND: begin
                alu_c  = reg_A & reg_B;
                zn_upd = 1'b1;
            end
            OP_OR: begin
                alu_c  = reg_A | reg_B;
                zn_upd = 1'b1;
            end
            OP_XOR: begin
                alu_c  = reg_A ^ reg_B;
                zn_upd = 1'b1;
            end
            OP_SLL, OP_SLA: begin
                alu_c  = reg_A << reg_B[3:0];
                zn_upd = 1'b1;
            end
            OP_SRL: begin
                alu_c  = reg_A >> reg_B[3:0];
                zn_upd = 1'b1;
            end
            OP_SRA: begin
                alu_c  = $signed(reg_A) >>> reg_B[3:0];
                zn_upd = 1'b1;
            end
            OP_LOAD: begin
                alu_c  = branch_addr;
            end
            OP_STORE: begin
                alu_c  = branch_addr;
                dw_nx  = 1'b1;
            end
            OP_JUMP, OP_JMPR, OP_BZ, OP_BNZ,
            OP_BN, OP_BNN, OP_BC, OP_BNC: begin
                alu_c  = branch_addr;
            end
            default: begin
                alu_c  = '0;
            end
        endcase
    end

    always_comb begin
        taken = 1'b0;
        unique case (op)
            OP_JUMP, OP_JMPR: taken = 1'b1;
            OP_BZ:            taken = zf;
            OP_BNZ:           taken = !zf;
            OP_BN:            taken = nf;
            OP_BNN:           taken = !nf;
            OP_BC:            taken = cf;
            OP_BNC:           taken = !cf;
            default:          taken = 1'b0;
        endcase
    end

    assign branch_flag = run && taken;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ir <= NOP;
            reg_C  <= '0;
            smdr1  <= '0;
            dw     <= 1'b0;
            zf     <= 1'b0;
            nf     <= 1'b0;
            cf     <= 1'b0;
        end else if (run) begin
            if (mul_start || mul_busy) begin
                mem_ir <= NOP;
                dw     <= 1'b0;
            end else if (mul_done) begin
                mem_ir <= ex_ir;
                reg_C  <= mul_product;
                dw     <= 1'b0;
                zf     <= (mul_product == 16'h0000);
                nf     <= mul_product[15];
            end else begin
                mem_ir <= ex_ir;
                reg_C  <= alu_c;
                smdr1  <= smdr;
                dw     <= dw_nx;
                cf     <= cf_nx;
                if (zn_upd) begin
                    zf <= (alu_c == 16'h0000);
                    nf <= alu_c[15];
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random ALU/branch
// traffic against an arithmetic reference model; MUL tests when MUL_EN is set.
`timescale 1ns/1ps
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        state = CPU_EXEC;
    logic [15:0] ex_ir = '0;
    logic [15:0] reg_A = '0;
    logic [15:0] reg_B = '0;
    logic [15:0] smdr  = '0;
    logic [15:0] mem_ir;
    logic [15:0] reg_C;
    logic [15:0] smdr1;
    logic        dw;
    logic        zf;
    logic        nf;
    logic        cf;
    logic        branch_flag;
    logic [15:0] branch_addr;
    logic        ex_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] e_c;
    logic [15:0] e_ir;
    logic        e_dw;
    logic        e_zf;
    logic        e_nf;
    logic        e_cf;
    logic        e_bf;

    ex_stage dut (
        .clock       (clock),
        .reset       (reset),
        .state       (state),
        .ex_ir       (ex_ir),
        .reg_A       (reg_A),
        .reg_B       (reg_B),
        .smdr        (smdr),
        .mem_ir      (mem_ir),
        .reg_C       (reg_C),
        .smdr1       (smdr1),
        .dw          (dw),
        .zf          (zf),
        .nf          (nf),
        .cf          (cf),
        .branch_flag (branch_flag),
        .branch_addr (branch_addr),
        .ex_busy     (ex_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reference model: result and flags straight from the ISA rules.
    task automatic issue(input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] s);
        longint r;
        logic [15:0] c;
        logic [15:0] v;
        bit alu;
        int n;
        ex_ir = {op, 11'($urandom)};
        reg_A = a;
        reg_B = b;
        smdr  = s;
        n     = int'(b[3:0]);
        alu   = 1'b1;
        c     = '0;
        e_bf  = 1'b0;
        e_dw  = 1'b0;
        case (op)
            OP_ADD, OP_ADDI, OP_LDIH: begin
                r = longint'(a) + longint'(b);
                c = 16'(r);
                e_cf = (r > 65535);
            end
            OP_ADDC: begin
                r = longint'(a) + longint'(b) + longint'(e_cf);
                c = 16'(r);
                e_cf = (r > 65535);
            end
            OP_SUB, OP_SUBI, OP_CMP: begin
                r = longint'(a) - longint'(b);
                c = 16'(r);
                e_cf = (r < 0);
            end
            OP_SUBC: begin
                r = longint'(a) - longint'(b) - longint'(e_cf);
                c = 16'(r);
                e_cf = (r < 0);
            end
            OP_AND: c = a & b;
            OP_OR:  c = a | b;
            OP_XOR: c = a ^ b;
            OP_SLL, OP_SLA: c = 16'(longint'(a) * (longint'(1) << n));
            OP_SRL: c = 16'(longint'(a) / (longint'(1) << n));
            OP_SRA: begin
                v = a;
                for (int i = 0; i < n; i++) v = {v[15], v[15:1]};
                c = v;
            end
            default: begin
                alu = 1'b0;
                case (op)
                    OP_LOAD:  c = a + b;
                    OP_STORE: begin c = a + b; e_dw = 1'b1; end
                    OP_JUMP, OP_JMPR: begin c = a + b; e_bf = 1'b1; end
                    OP_BZ:  begin c = a + b; e_bf = e_zf;  end
                    OP_BNZ: begin c = a + b; e_bf = !e_zf; end
                    OP_BN:  begin c = a + b; e_bf = e_nf;  end
                    OP_BNN: begin c = a + b; e_bf = !e_nf; end
                    OP_BC:  begin c = a + b; e_bf = e_cf;  end
                    OP_BNC: begin c = a + b; e_bf = !e_cf; end
                    default: c = '0;
                endcase
            end
        endcase
        if (alu) begin
            e_zf = (c == 16'h0000);
            e_nf = c[15];
        end
        e_c  = c;
        e_ir = ex_ir;
    endtask

    task automatic test_reset;
        ex_ir = 16'hFFFF;
        reg_A = 16'h1234;
        reg_B = 16'h4321;
        smdr  = 16'hAAAA;
        reset = 1'b0;
        #3;
        if ({mem_ir, reg_C, smdr1, dw, zf, nf, cf} !== 52'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0",
                     {mem_ir, reg_C, smdr1, dw, zf, nf, cf});
        end
        n_checks++;
        tick();
        if ({mem_ir, reg_C, smdr1, dw, zf, nf, cf} !== 52'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0",
                     {mem_ir, reg_C, smdr1, dw, zf, nf, cf});
        end
        n_checks++;
        ex_ir = NOP;
        reset = 1'b1;
        e_zf = 0; e_nf = 0; e_cf = 0;
        e_c = 0; e_ir = 0; e_dw = 0;
    endtask

    task automatic test_add;
        issue(OP_ADD, 16'hFFFF, 16'h0001, 16'h0);
        tick();
        if ({reg_C, zf, nf, cf, dw} !== {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_wrap: got C=%h z%b n%b c%b dw%b want C=0000 z1 n0 c1 dw0",
                     reg_C, zf, nf, cf, dw);
        end
        n_checks++;
    endtask

    task automatic test_store;
        issue(OP_STORE, 16'h0010, 16'h0004, 16'hBEEF);
        tick();
        if ({reg_C, smdr1, dw, zf, cf} !== {16'h0014, 16'hBEEF, 1'b1, e_zf, e_cf}) begin
            n_fail++;
            $display("FAIL store: got C=%h smdr1=%h dw=%b z%b c%b want 0014 BEEF 1 z%b c%b",
                     reg_C, smdr1, dw, zf, cf, e_zf, e_cf);
        end
        n_checks++;
        issue(OP_NOP, 16'h5555, 16'h1111, 16'h0);
        tick();
        if ({dw, reg_C} !== {1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL store_then_nop: got dw=%b C=%h want dw=0 C=0000", dw, reg_C);
        end
        n_checks++;
    endtask

    task automatic test_branch;
        issue(OP_SUB, 16'h0003, 16'h0005, 16'h0);
        tick();
        if ({reg_C, nf, cf, zf} !== {16'hFFFE, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow: got C=%h n%b c%b z%b want FFFE n1 c1 z0",
                     reg_C, nf, cf, zf);
        end
        n_checks++;
        issue(OP_BN, 16'h0020, 16'h0002, 16'h0);
        #1;
        if ({branch_flag, branch_addr} !== {1'b1, 16'h0022}) begin
            n_fail++;
            $display("FAIL bn_taken: got bf=%b addr=%h want bf=1 addr=0022",
                     branch_flag, branch_addr);
        end
        n_checks++;
        issue(OP_BNN, 16'h0020, 16'h0002, 16'h0);
        #1;
        if (branch_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL bnn_not_taken: got bf=%b want 0", branch_flag);
        end
        n_checks++;
        tick();
        if ({reg_C, mem_ir, nf, cf} !== {16'h0022, e_ir, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_regc: got C=%h ir=%h n%b c%b want 0022 %h n1 c1",
                     reg_C, mem_ir, nf, cf, e_ir);
        end
        n_checks++;
    endtask

    task automatic test_idle;
        logic [15:0] c0;
        logic [15:0] ir0;
        logic [2:0]  f0;
        c0  = reg_C;
        ir0 = mem_ir;
        f0  = {zf, nf, cf};
        state = CPU_IDLE;
        ex_ir = {OP_JUMP, 11'h0};
        reg_A = 16'h1000;
        reg_B = 16'h0234;
        #1;
        if (branch_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_branch: got bf=%b want 0", branch_flag);
        end
        n_checks++;
        ex_ir = {OP_ADD, 11'h0};
        reg_A = 16'hFFFF;
        reg_B = 16'h0007;
        tick();
        tick();
        if ({reg_C, mem_ir, zf, nf, cf} !== {c0, ir0, f0}) begin
            n_fail++;
            $display("FAIL idle_hold: got C=%h ir=%h f=%b want C=%h ir=%h f=%b",
                     reg_C, mem_ir, {zf, nf, cf}, c0, ir0, f0);
        end
        n_checks++;
        state = CPU_EXEC;
    endtask

    task automatic test_random_alu;
        logic [4:0] op;
        for (int k = 0; k < 80; k++) begin
            op = 5'($urandom_range(0, 31));
`ifdef MUL_EN
            if (op == OP_MUL) op = OP_ADDC;
`endif
            issue(op, 16'($urandom), 16'($urandom), 16'($urandom));
            #1;
            if ({branch_flag, branch_addr, ex_busy} !== {e_bf, reg_A + reg_B, 1'b0}) begin
                n_fail++;
                $display("FAIL rand_branch op=%0d: got bf=%b addr=%h busy=%b want bf=%b addr=%h busy=0",
                         op, branch_flag, branch_addr, ex_busy, e_bf, reg_A + reg_B);
            end
            n_checks++;
            tick();
            if ({reg_C, mem_ir, dw, zf, nf, cf} !== {e_c, e_ir, e_dw, e_zf, e_nf, e_cf}) begin
                n_fail++;
                $display("FAIL rand_alu op=%0d A=%h B=%h: got C=%h ir=%h dw%b z%b n%b c%b want C=%h ir=%h dw%b z%b n%b c%b",
                         op, reg_A, reg_B, reg_C, mem_ir, dw, zf, nf, cf,
                         e_c, e_ir, e_dw, e_zf, e_nf, e_cf);
            end
            n_checks++;
        end
    endtask

`ifdef MUL_EN
    // Presents one MUL and clocks until it retires into mem_ir.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input int idle_at, input int idle_len,
                           output int edges, output int busy_n, output int bad);
        logic [15:0] ir;
        bit was_exec;
        bit fin;
        ir     = {OP_MUL, 11'($urandom)};
        ex_ir  = ir;
        reg_A  = a;
        reg_B  = b;
        edges  = 0;
        busy_n = 0;
        bad    = 0;
        fin    = 0;
        while (!fin && edges < 80) begin
            state = (edges >= idle_at && edges < idle_at + idle_len) ? CPU_IDLE : CPU_EXEC;
            was_exec = (state == CPU_EXEC);
            #1;
            if (was_exec && ex_busy) busy_n++;
            tick();
            edges++;
            if (was_exec && mem_ir === ir) fin = 1;
            else if (was_exec && (mem_ir !== NOP || dw !== 1'b0)) bad++;
        end
        state = CPU_EXEC;
        e_c   = 16'(longint'(a) * longint'(b));
        e_zf  = (e_c == 16'h0000);
        e_nf  = e_c[15];
        e_ir  = ir;
        e_dw  = 1'b0;
        ex_ir = NOP;
    endtask

    task automatic test_mul;
        int edges;
        int busy_n;
        int bad;
        issue(OP_ADD, 16'hFFFF, 16'h0001, 16'h0);
        tick();
        run_mul(16'h0123, 16'h0010, 999, 0, edges, busy_n, bad);
        if ({edges, busy_n, bad} !== {32'd17, 32'd16, 32'd0}) begin
            n_fail++;
            $display("FAIL mul_timing: got edges=%0d busy=%0d bad_bubbles=%0d want 17 16 0",
                     edges, busy_n, bad);
        end
        n_checks++;
        if ({reg_C, zf, nf, cf} !== {16'h1230, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mul_result: got C=%h z%b n%b c%b want 1230 z0 n0 c1",
                     reg_C, zf, nf, cf);
        end
        n_checks++;
        for (int k = 0; k < 4; k++) begin
            run_mul(16'($urandom), 16'($urandom), 999, 0, edges, busy_n, bad);
            if ({edges, bad, reg_C, mem_ir, zf, nf, cf} !==
                {32'd17, 32'd0, e_c, e_ir, e_zf, e_nf, e_cf}) begin
                n_fail++;
                $display("FAIL mul_rand: got edges=%0d bad=%0d C=%h z%b n%b c%b want 17 0 C=%h z%b n%b c%b",
                         edges, bad, reg_C, zf, nf, cf, e_c, e_zf, e_nf, e_cf);
            end
            n_checks++;
        end
    endtask

    task automatic test_mul_idle;
        int edges;
        int busy_n;
        int bad;
        run_mul(16'h00FF, 16'h0101, 6, 5, edges, busy_n, bad);
        if ({edges, bad, reg_C} !== {32'd22, 32'd0, e_c}) begin
            n_fail++;
            $display("FAIL mul_idle: got edges=%0d bad=%0d C=%h want 22 0 C=%h",
                     edges, bad, reg_C, e_c);
        end
        n_checks++;
    endtask

    task automatic test_mul_reset;
        int edges;
        int busy_n;
        int bad;
        ex_ir = {OP_MUL, 11'h0};
        reg_A = 16'h0F0F;
        reg_B = 16'h0033;
        for (int k = 0; k < 7; k++) tick();
        reset = 1'b0;
        #1;
        if ({mem_ir, reg_C, smdr1, dw, zf, nf, cf, ex_busy} !== {52'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL mul_reset: got %h busy=%b want 0 busy=1",
                     {mem_ir, reg_C, smdr1, dw, zf, nf, cf}, ex_busy);
        end
        n_checks++;
        ex_ir = NOP;
        #1;
        if (ex_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_reset_idle: got busy=%b want 0", ex_busy);
        end
        n_checks++;
        reset = 1'b1;
        e_zf = 0; e_nf = 0; e_cf = 0;
        run_mul(16'h0F0F, 16'h0033, 999, 0, edges, busy_n, bad);
        if ({edges, busy_n, reg_C} !== {32'd17, 32'd16, e_c}) begin
            n_fail++;
            $display("FAIL mul_after_reset: got edges=%0d busy=%0d C=%h want 17 16 C=%h",
                     edges, busy_n, reg_C, e_c);
        end
        n_checks++;
    endtask
`else
    task automatic test_mul_disabled;
        issue(OP_SUB, 16'h0001, 16'h0002, 16'h0);
        tick();
        issue(OP_MUL, 16'h0123, 16'h0010, 16'h0);
        #1;
        if (ex_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nomul_busy: got %b want 0", ex_busy);
        end
        n_checks++;
        tick();
        if ({reg_C, mem_ir, zf, nf, cf} !== {16'h0000, e_ir, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL nomul_nop: got C=%h ir=%h z%b n%b c%b want 0000 %h z0 n1 c1",
                     reg_C, mem_ir, zf, nf, cf, e_ir);
        end
        n_checks++;
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_add();
        test_store();
        test_branch();
        test_idle();
        test_random_alu();
`ifdef MUL_EN
        test_mul();
        test_mul_idle();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        test_random_alu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the Mipu 16-bit five-stage pipeline, between ID and MEM. Each `exec` cycle it latches the ALU result, store data, write-enable and instruction for MEM, and holds the Z/N/C flags. It resolves conditional branches combinationally for IF/ID. An optional 16-cycle iterative multiplier stalls the front of the pipe while it runs.

## Interface
Parameters: none. Opcodes, `exec`/`idle` and `NOP` come from the shared define file.
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- state  in  1  CPU run state; `exec` advances the stage, `idle` freezes all registers
- ex_ir  in  16  instruction in EX; opcode = ex_ir[15:11]
- reg_A  in  16  first operand from ID
- reg_B  in  16  second operand from ID (register or immediate, already extended/positioned by ID)
- smdr  in  16  store data from ID
- mem_ir  out  16  registered instruction to MEM
- reg_C  out  16  registered ALU result / memory address to MEM
- smdr1  out  16  registered store data to MEM
- dw  out  1  registered data write enable to MEM; 1 only for STORE
- zf, nf, cf  out  1 each  registered flags
- branch_flag  out  1  combinational; 1 = taken jump/branch in EX
- branch_addr  out  16  combinational target, reg_A + reg_B
- ex_busy  out  1  combinational stall request to IF/ID; 0 when MUL_EN is not defined

## Operation
- All arithmetic is 16-bit modulo; ADD/SUB use a 17-bit internal sum.
- ADD, ADDI, LDIH: C = A + B.
  - cf = carry out.
- ADDC: C = A + B + cf.
- SUB, SUBI, CMP: C = A − B.
  - SUBC subtracts an extra cf.
  - cf = borrow.
  - CMP updates flags only; reg_C is written but ignored downstream.
- AND / OR / XOR: bitwise; cf unchanged.
- SLL / SRL / SLA / SRA: A shifted by B[3:0]; cf unchanged.
- Flags: zf = (C == 0) and nf = C[15], for all ALU ops above. LOAD, STORE, jumps, branches, NOP and HALT leave the flags unchanged.
- LOAD / STORE: reg_C = A + B.
  - STORE sets dw = 1 and smdr1 = smdr.
  - dw = 0 for every other op.
- Jumps and branches:
  - JUMP and JMPR are always taken.
  - BZ/BNZ, BN/BNN and BC/BNC test the registered zf, nf and cf of the current cycle.
  - branch_flag is only ever asserted while state == `exec`.
  - reg_C = branch_addr.
- Unlisted opcodes behave as NOP: mem_ir <= ex_ir, reg_C <= 0, dw <= 0, flags held.
- Multiplier FSM (MUL_EN only), states IDLE and MULT:
  - IDLE with opcode MUL: load multiplicand and multiplier from A and B, clear the 4-bit count, go to MULT. At this edge mem_ir <= NOP and dw <= 0 (bubble).
  - MULT: one shift-add per cycle. count == 15 is the final iteration; at that edge reg_C <= product[15:0], mem_ir <= ex_ir, zf/nf update, cf is held, and the FSM returns to IDLE.
  - Every other MULT edge issues a bubble: mem_ir <= NOP, dw <= 0.
  - ex_busy = (IDLE && op == MUL) || (MULT && count != 15). It drops in the final cycle so ID advances on the same edge as completion.

## Timing
- Non-MUL ops: result at MEM inputs one edge after being presented. A back-to-back dependent instruction sees the flags on the next cycle.
- MUL: occupies EX for 17 cycles and asserts ex_busy for 16. The result is in reg_C at the 17th edge after the MUL is first presented.
- state == `idle`: every register and the FSM hold. A multiply resumes when `exec` returns.
- Reset at any time, including mid-multiply:
  - mem_ir, reg_C and smdr1 = 16'h0000; dw, zf, nf and cf = 0.
  - FSM = IDLE, count = 0. ex_busy then follows ex_ir combinationally.
- While ex_busy = 1, ID holds ex_ir, reg_A and reg_B stable. EX does not re-sample the operands during MULT.

## Configuration
- MUL_EN defined: the MUL opcode, FSM and ex_busy logic behave as described above.
- MUL_EN undefined: MUL decodes as unlisted (NOP), ex_busy is tied to 0, and no multiplier logic is instantiated.

## Structure
- The shared define file holds:
  - all opcode constants, including MUL;
  - `exec`/`idle`;
  - `NOP` = 16'h0000;
  - FSM state encodings.
- Sub-module `mul16_iter`: start/busy/done handshake, 16-bit multiplicand and multiplier in, 16-bit product out. Instantiated only under MUL_EN.

## Test plan
- Reset, then ADD with A=16'hFFFF, B=16'h0001 → reg_C=0, zf=1, cf=1, nf=0, dw=0 after one edge.
- STORE with A=16'h0010, B=16'h0004, smdr=16'hBEEF → reg_C=16'h0014, smdr1=16'hBEEF, dw=1. The following NOP → dw=0.
- SUB 3−5 then BN with A=16'h0020, B=16'h0002 → nf=1, cf=1, and in the BN cycle branch_flag=1, branch_addr=16'h0022. BNN in that cycle → branch_flag=0.
- MUL_EN defined, MUL A=16'h0123, B=16'h0010:
  - ex_busy is high for exactly 16 cycles;
  - mem_ir is NOP during the bubbles;
  - reg_C=16'h1230 at edge 17;
  - cf is unchanged.
- MUL with state dropped to `idle` for 5 cycles mid-run → result is delayed exactly 5 cycles. Reset asserted mid-MUL → all outputs 0, FSM IDLE.
- MUL_EN undefined: MUL → ex_busy=0, reg_C=0, flags held.
